// File: rtl/alarm_siren_sequencer.sv
// alarm_siren_sequencer: arm/disarm state machine with entry delay and
// alarm duration. It drives the registered siren enable for the tone generator.
// Optional arm/disarm chirp: define SIREN_CHIRP_EN.
module alarm_siren_sequencer #(
    parameter int TICK_DIV    = 50000000,
    parameter int ENTRY_DELAY = 10,
    parameter int ALARM_TIME  = 30,
    parameter int CHIRP_LEN   = 5000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       arm_request,
    input  logic       disarm_request,
    input  logic       sensor_trip,
    output logic       siren,
    output logic       armed,
    output logic [2:0] state_code,
    output logic [7:0] alarm_count
);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_ARMED    = 3'd1,
        S_ENTRY    = 3'd2,
        S_ALARM    = 3'd3,
        S_REARM    = 3'd4
    } state_t;

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_T = (ENTRY_DELAY > ALARM_TIME) ? ENTRY_DELAY : ALARM_TIME;
    localparam int TMR_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [TMR_W-1:0] ENTRY_LAST = TMR_W'(ENTRY_DELAY - 1);
    localparam logic [TMR_W-1:0] ALARM_LAST = TMR_W'(ALARM_TIME - 1);

    state_t            state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [7:0]        count_q, count_d;
    logic              siren_q, siren_d;
    logic              armed_q, armed_d;
    logic              tick;
    logic              transition;

`ifdef SIREN_CHIRP_EN
    localparam int CHIRP_W = (CHIRP_LEN > 1) ? $clog2(CHIRP_LEN + 1) : 1;
    logic [CHIRP_W-1:0] chirp_q, chirp_d;
    logic               chirp_start;
`endif

    // Next state: disarm beats everything, including a same-cycle timer expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_DISARMED: if (arm_request && !disarm_request && !sensor_trip) state_d = S_ARMED;
            S_ARMED: begin
                if (disarm_request)   state_d = S_DISARMED;
                else if (sensor_trip) state_d = S_ENTRY;
            end
            S_ENTRY: begin
                if (disarm_request)                  state_d = S_DISARMED;
                else if (tick && tmr_q == ENTRY_LAST) state_d = S_ALARM;
            end
            S_ALARM: begin
                if (disarm_request)                  state_d = S_DISARMED;
                else if (tick && tmr_q == ALARM_LAST) state_d = S_REARM;
            end
            S_REARM: begin
                if (disarm_request)    state_d = S_DISARMED;
                else if (!sensor_trip) state_d = S_ARMED;
            end
            default: state_d = S_DISARMED;
        endcase
    end

    // Prescaler/tick timer restart on every state change so delays are exact.
    always_comb begin
        tick       = (pre_q == PRE_LAST);
        transition = (state_d != state_q);
        pre_d      = (transition || tick) ? '0 : pre_q + 1'b1;
        tmr_d      = tmr_q;
        if (transition)
            tmr_d = '0;
        else if (tick && (state_q == S_ENTRY || state_q == S_ALARM))
            tmr_d = tmr_q + 1'b1;
    end

    // Status: saturating alarm counter, armed flag and siren for the next state.
    always_comb begin
        count_d = count_q;
        if (state_d == S_ALARM && state_q != S_ALARM && count_q != 8'hFF)
            count_d = count_q + 8'd1;
        armed_d = (state_d != S_DISARMED);
`ifdef SIREN_CHIRP_EN
        // A refused arm never reaches ARMED, so it cannot start a chirp.
        chirp_start = (state_q == S_DISARMED && state_d == S_ARMED) ||
                      (disarm_request && state_q != S_DISARMED);
        if (chirp_start)
            chirp_d = CHIRP_W'(CHIRP_LEN);
        else if (chirp_q != '0)
            chirp_d = chirp_q - 1'b1;
        else
            chirp_d = '0;
        siren_d = (state_d == S_ALARM) || (chirp_d != '0);
`else
        siren_d = (state_d == S_ALARM);
`endif
    end

    // State and registered outputs; reset clears the siren asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_DISARMED;
            pre_q   <= '0;
            tmr_q   <= '0;
            count_q <= '0;
            siren_q <= 1'b0;
            armed_q <= 1'b0;
`ifdef SIREN_CHIRP_EN
            chirp_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            tmr_q   <= tmr_d;
            count_q <= count_d;
            siren_q <= siren_d;
            armed_q <= armed_d;
`ifdef SIREN_CHIRP_EN
            chirp_q <= chirp_d;
`endif
        end
    end

    assign siren       = siren_q;
    assign armed       = armed_q;
    assign state_code  = state_q;
    assign alarm_count = count_q;

endmodule
